// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the RAM port arbiter: default widths, requester indices,
// read-return tag encoding, FSM states and the grant priority function.
package arb_pkg;
  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 256;

  localparam logic [1:0] P_CAM = 2'd0;
  localparam logic [1:0] P_TM  = 2'd1;
  localparam logic [1:0] P_HDR = 2'd2;
  localparam logic [1:0] P_VGA = 2'd3;

  localparam logic TAG_HDR = 1'b0;
  localparam logic TAG_VGA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // CAM beats VGA beats the HDR/TM pair; rr_tm selects which of the pair wins a tie.
  function automatic logic [1:0] pick_winner(input logic [3:0] elig, input logic rr_tm);
    logic [1:0] w;
    w = P_TM;
    if (elig[P_CAM])                   w = P_CAM;
    else if (elig[P_VGA])              w = P_VGA;
    else if (elig[P_HDR] && elig[P_TM]) w = rr_tm ? P_TM : P_HDR;
    else if (elig[P_HDR])              w = P_HDR;
    return w;
  endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// RAM controller command/return bus; the arbiter is the master side.
interface ram_port_arbiter_if
  import arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_busy;
  logic              ram_rd_valid;
  logic [DATA_W-1:0] ram_rd_data;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_busy, ram_rd_valid, ram_rd_data
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_busy, ram_rd_valid, ram_rd_data
  );
endinterface

// File: rtl/ram_port_arbiter_tag_fifo.sv
// In-order tag FIFO remembering which reader owns each outstanding RAM read.
module arb_tag_fifo #(
  parameter int TAG_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic pop_tag,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(TAG_DEPTH);

  logic [TAG_DEPTH-1:0] mem;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (int'(count) == TAG_DEPTH);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_tag = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Four-requester arbiter for the single RAM controller port with pending slots and read-return routing.
// Optional ARB_STATS_EN adds saturating per-requester grant counters on grant_cnt.
module ram_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_wr_req,
  input  logic [ADDR_W-1:0] cam_wr_addr,
  input  logic [DATA_W-1:0] cam_wr_data,
  input  logic              tm_wr_req,
  input  logic [ADDR_W-1:0] tm_wr_addr,
  input  logic [DATA_W-1:0] tm_wr_data,
  input  logic              hdr_rd_req,
  input  logic [ADDR_W-1:0] hdr_rd_addr,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic [3:0]        slot_busy,
  output logic              hdr_rd_valid,
  output logic              vga_rd_valid,
  output logic [DATA_W-1:0] rd_data,
  ram_port_arbiter_if.master ram,
  output logic [4:0]        err_flags
`ifdef ARB_STATS_EN
  ,
  output logic [4*16-1:0]   grant_cnt
`endif
);
  arb_state_e        state_q, state_d;
  logic [3:0]        req_in, slot_vld, elig, granted, accept;
  logic [ADDR_W-1:0] addr_in   [4];
  logic [ADDR_W-1:0] slot_addr [4];
  logic [DATA_W-1:0] wr_data_in [2];
  logic [DATA_W-1:0] slot_data  [2];
  logic [1:0]        winner, gnt_sel_q;
  logic              rr_tm_q, launch, issue;
  logic              tag_push, tag_pop, pop_tag, tag_full, tag_empty;
  logic              ram_req_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;

  assign req_in         = {vga_rd_req, hdr_rd_req, tm_wr_req, cam_wr_req};
  assign addr_in[P_CAM] = cam_wr_addr;
  assign addr_in[P_TM]  = tm_wr_addr;
  assign addr_in[P_HDR] = hdr_rd_addr;
  assign addr_in[P_VGA] = vga_rd_addr;
  assign wr_data_in[0]  = cam_wr_data;
  assign wr_data_in[1]  = tm_wr_data;

  assign issue     = (state_q == ST_ISSUE);
  assign slot_busy = slot_vld;

  // Reads are held back while every tag is in flight; writes stay eligible.
  assign elig   = {slot_vld[P_VGA] & ~tag_full, slot_vld[P_HDR] & ~tag_full,
                   slot_vld[P_TM], slot_vld[P_CAM]};
  assign winner = pick_winner(elig, rr_tm_q);

  always_comb begin
    granted = '0;
    accept  = '0;
    for (int i = 0; i < 4; i++) begin
      granted[i] = issue && (gnt_sel_q == 2'(i));
      accept[i]  = req_in[i] && (!slot_vld[i] || granted[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld  <= '0;
      err_flags <= '0;
    end else begin
      slot_vld       <= accept | (slot_vld & ~granted);
      err_flags[3:0] <= err_flags[3:0] | (req_in & slot_vld & ~granted);
      err_flags[4]   <= err_flags[4] | (ram.ram_rd_valid & tag_empty);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i]) slot_addr[i] <= addr_in[i];
    end
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) slot_data[i] <= wr_data_in[i];
    end
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!ram.ram_busy && |elig) begin
          launch  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---- command register stage: decision in IDLE, strobe during ISSUE ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      gnt_sel_q   <= P_CAM;
      rr_tm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ram_req_q <= launch;
      if (launch) begin
        gnt_sel_q   <= winner;
        ram_we_q    <= (winner == P_CAM) || (winner == P_TM);
        ram_addr_q  <= slot_addr[winner];
        ram_wdata_q <= slot_data[winner[0]];
        if (winner == P_HDR) rr_tm_q <= 1'b1;
        if (winner == P_TM)  rr_tm_q <= 1'b0;
      end
    end
  end

  assign ram.ram_req   = ram_req_q;
  assign ram.ram_we    = ram_we_q;
  assign ram.ram_addr  = ram_addr_q;
  assign ram.ram_wdata = ram_wdata_q;

  assign tag_push = issue && ((gnt_sel_q == P_HDR) || (gnt_sel_q == P_VGA));
  assign tag_pop  = ram.ram_rd_valid && !tag_empty;

  arb_tag_fifo #(.TAG_DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tag_push),
    .push_tag ((gnt_sel_q == P_VGA) ? TAG_VGA : TAG_HDR),
    .pop      (tag_pop),
    .pop_tag  (pop_tag),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // ---- read return stage: data and owner strobe one cycle after ram_rd_valid ----
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_rd_valid <= 1'b0;
      vga_rd_valid <= 1'b0;
      rd_data      <= '0;
    end else begin
      hdr_rd_valid <= tag_pop && (pop_tag == TAG_HDR);
      vga_rd_valid <= tag_pop && (pop_tag == TAG_VGA);
      if (tag_pop) rd_data <= ram.ram_rd_data;
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt_q [4];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst)             cnt_q[i] <= '0;
      else if (granted[i]) cnt_q[i] <= sat_inc16(cnt_q[i]);
    end
  end

  assign grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: transaction-level model checked every cycle plus literal expectations.
module tb_ram_port_arbiter;
  logic          clk;
  logic          rst;
  logic          cam_wr_req, tm_wr_req, hdr_rd_req, vga_rd_req;
  logic [24:0]   cam_wr_addr, tm_wr_addr, hdr_rd_addr, vga_rd_addr;
  logic [255:0]  cam_wr_data, tm_wr_data;
  logic [3:0]    slot_busy;
  logic          hdr_rd_valid, vga_rd_valid;
  logic [255:0]  rd_data;
  logic [4:0]    err_flags;
`ifdef ARB_STATS_EN
  logic [63:0]   grant_cnt;
`endif

  ram_port_arbiter_if #(.ADDR_W(25), .DATA_W(256)) ram_bus ();

  ram_port_arbiter #(.ADDR_W(25), .DATA_W(256), .TAG_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cam_wr_req   (cam_wr_req),
    .cam_wr_addr  (cam_wr_addr),
    .cam_wr_data  (cam_wr_data),
    .tm_wr_req    (tm_wr_req),
    .tm_wr_addr   (tm_wr_addr),
    .tm_wr_data   (tm_wr_data),
    .hdr_rd_req   (hdr_rd_req),
    .hdr_rd_addr  (hdr_rd_addr),
    .vga_rd_req   (vga_rd_req),
    .vga_rd_addr  (vga_rd_addr),
    .slot_busy    (slot_busy),
    .hdr_rd_valid (hdr_rd_valid),
    .vga_rd_valid (vga_rd_valid),
    .rd_data      (rd_data),
    .ram          (ram_bus.master),
    .err_flags    (err_flags)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: pending requests per requester, a queue of outstanding read owners,
  // and a "cycles until the port is free again" count.
  logic [3:0]   m_pend;
  logic [24:0]  m_paddr [4];
  logic [255:0] m_pdata [4];
  int           m_tags [$];
  bit           m_rr_hdr;
  logic [4:0]   m_err;
  int           m_hold;
  logic         m_req, m_we, m_hv, m_vv;
  int           m_port;
  logic [24:0]  m_addr;
  logic [255:0] m_wdata, m_rdata;

  task automatic model_step();
    logic [3:0]   rq;
    logic [3:0]   elig;
    logic [24:0]  ai [4];
    logic [255:0] di [4];
    int win, gnt, t;
    rq    = {vga_rd_req, hdr_rd_req, tm_wr_req, cam_wr_req};
    ai[0] = cam_wr_addr; ai[1] = tm_wr_addr; ai[2] = hdr_rd_addr; ai[3] = vga_rd_addr;
    di[0] = cam_wr_data; di[1] = tm_wr_data; di[2] = '0;          di[3] = '0;
    if (rst) begin
      m_pend = '0; m_err = '0; m_tags.delete(); m_rr_hdr = 1'b1; m_hold = 0;
      m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_hv = 1'b0; m_vv = 1'b0; m_rdata = '0; m_port = 0;
      return;
    end
    gnt = m_req ? m_port : -1;
    for (int i = 0; i < 4; i++) elig[i] = m_pend[i] && (i < 2 || m_tags.size() < 8);
    win = -1;
    if (m_hold == 0 && !ram_bus.ram_busy) begin
      if (elig[0])                win = 0;
      else if (elig[3])           win = 3;
      else if (elig[2] && elig[1]) win = m_rr_hdr ? 2 : 1;
      else if (elig[2])           win = 2;
      else if (elig[1])           win = 1;
    end
    m_hv = 1'b0;
    m_vv = 1'b0;
    if (ram_bus.ram_rd_valid) begin
      if (m_tags.size() == 0) m_err[4] = 1'b1;
      else begin
        t = m_tags.pop_front();
        m_hv = (t == 0);
        m_vv = (t == 1);
        m_rdata = ram_bus.ram_rd_data;
      end
    end
    if (gnt == 2 || gnt == 3) m_tags.push_back(gnt == 3 ? 1 : 0);
    if (win >= 0) begin
      m_req = 1'b1; m_port = win; m_we = (win < 2);
      m_addr = m_paddr[win]; m_wdata = m_pdata[win]; m_hold = 2;
      if (win == 2) m_rr_hdr = 1'b0;
      if (win == 1) m_rr_hdr = 1'b1;
    end else begin
      m_req = 1'b0;
      if (m_hold > 0) m_hold--;
    end
    for (int i = 0; i < 4; i++) begin
      if (rq[i]) begin
        if (!m_pend[i] || gnt == i) begin
          m_pend[i] = 1'b1; m_paddr[i] = ai[i]; m_pdata[i] = di[i];
        end else m_err[i] = 1'b1;
      end else if (gnt == i) m_pend[i] = 1'b0;
    end
  endtask

  logic [24:0]  log_addr [$];
  logic [255:0] log_data [$];
  int           log_cyc  [$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ram_req", ram_bus.ram_req, m_req);
      if (m_req) begin
        chk("ram_we", ram_bus.ram_we, m_we);
        chk("ram_addr", ram_bus.ram_addr, m_addr);
        if (m_we) chk("ram_wdata", ram_bus.ram_wdata, m_wdata);
      end
      chk("slot_busy", slot_busy, m_pend);
      chk("err_flags", err_flags, m_err);
      chk("hdr_rd_valid", hdr_rd_valid, m_hv);
      chk("vga_rd_valid", vga_rd_valid, m_vv);
      if (m_hv || m_vv) chk("rd_data", rd_data, m_rdata);
    end
    if (ram_bus.ram_req) begin
      log_addr.push_back(ram_bus.ram_addr);
      log_data.push_back(ram_bus.ram_wdata);
      log_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ret(input logic [255:0] d);
    ram_bus.ram_rd_valid = 1'b1;
    ram_bus.ram_rd_data  = d;
    tick();
    ram_bus.ram_rd_valid = 1'b0;
  endtask

  localparam logic [255:0] D1 = {8{32'hCAFE_0001}};
  localparam logic [255:0] D2 = {8{32'h1234_5678}};
  localparam logic [255:0] DT = {8{32'h0BAD_F00D}};
  localparam logic [255:0] R1 = {8{32'hA5A5_0001}};
  localparam logic [255:0] R2 = {8{32'h5A5A_0002}};
  localparam logic [255:0] DA = {8{32'hDEAD_000A}};
  localparam logic [255:0] DB = {8{32'hDEAD_000B}};

  int base;

  initial begin
    rst = 1'b1;
    cam_wr_req = 0; tm_wr_req = 0; hdr_rd_req = 0; vga_rd_req = 0;
    cam_wr_addr = '0; tm_wr_addr = '0; hdr_rd_addr = '0; vga_rd_addr = '0;
    cam_wr_data = '0; tm_wr_data = '0;
    ram_bus.ram_busy = 1'b0; ram_bus.ram_rd_valid = 1'b0; ram_bus.ram_rd_data = '0;
    idle(2);
    chk("rst_ram_req", ram_bus.ram_req, 1'b0);
    chk("rst_ram_we", ram_bus.ram_we, 1'b0);
    chk("rst_ram_addr", ram_bus.ram_addr, 25'h0);
    chk("rst_ram_wdata", ram_bus.ram_wdata, 256'h0);
    chk("rst_slot_busy", slot_busy, 4'b0000);
    chk("rst_rd_valids", {hdr_rd_valid, vga_rd_valid}, 2'b00);
    chk("rst_rd_data", rd_data, 256'h0);
    chk("rst_err_flags", err_flags, 5'b00000);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Single camera write: strobe two cycles after the request pulse.
    cam_wr_req = 1; cam_wr_addr = 25'h100; cam_wr_data = D1;
    tick();
    cam_wr_req = 0;
    chk("t1_slot_loaded", slot_busy, 4'b0001);
    chk("t1_no_req_yet", ram_bus.ram_req, 1'b0);
    tick();
    chk("t1_req", ram_bus.ram_req, 1'b1);
    chk("t1_we", ram_bus.ram_we, 1'b1);
    chk("t1_addr", ram_bus.ram_addr, 25'h100);
    chk("t1_wdata", ram_bus.ram_wdata, D1);
    idle(3);

    // All four at once: CAM, VGA, HDR, TM, three cycles apart.
    base = log_addr.size();
    cam_wr_req = 1; cam_wr_addr = 25'h200; cam_wr_data = D2;
    tm_wr_req  = 1; tm_wr_addr  = 25'h201; tm_wr_data  = DT;
    hdr_rd_req = 1; hdr_rd_addr = 25'h202;
    vga_rd_req = 1; vga_rd_addr = 25'h203;
    tick();
    cam_wr_req = 0; tm_wr_req = 0; hdr_rd_req = 0; vga_rd_req = 0;
    idle(13);
    chk("t2_grant_count", 32'(log_addr.size() - base), 32'd4);
    if (log_addr.size() - base == 4) begin
      chk("t2_order0", log_addr[base],   25'h200);
      chk("t2_order1", log_addr[base+1], 25'h203);
      chk("t2_order2", log_addr[base+2], 25'h202);
      chk("t2_order3", log_addr[base+3], 25'h201);
      chk("t2_spacing", 32'(log_cyc[base+3] - log_cyc[base]), 32'd9);
    end
    ret(R1);
    chk("t2_vga_ret", {vga_rd_valid, hdr_rd_valid}, 2'b10);
    chk("t2_vga_data", rd_data, R1);
    ret(R2);
    chk("t2_hdr_ret", {vga_rd_valid, hdr_rd_valid}, 2'b01);
    chk("t2_hdr_data", rd_data, R2);
    idle(2);

    // Busy controller holds off an HDR read for 20 cycles.
    base = log_addr.size();
    ram_bus.ram_busy = 1'b1;
    hdr_rd_req = 1; hdr_rd_addr = 25'h300;
    tick();
    hdr_rd_req = 0;
    idle(19);
    chk("t3_hdr_pending", slot_busy[2], 1'b1);
    chk("t3_none_issued", 32'(log_addr.size() - base), 32'd0);
    ram_bus.ram_busy = 1'b0;
    tick();
    chk("t3_req_after_busy", ram_bus.ram_req, 1'b1);
    chk("t3_addr", ram_bus.ram_addr, 25'h300);
    idle(3);
    ret(R1);
    idle(2);

    // Nine VGA reads with no returns: the ninth waits for a free tag.
    base = log_addr.size();
    for (int i = 0; i < 9; i++) begin
      vga_rd_req = 1; vga_rd_addr = 25'h3000 + 25'(i);
      tick();
      vga_rd_req = 0;
      idle(2);
    end
    idle(4);
    chk("t4_eight_issued", 32'(log_addr.size() - base), 32'd8);
    chk("t4_ninth_held", slot_busy, 4'b1000);
    ret(R2);
    chk("t4_first_ret", vga_rd_valid, 1'b1);
    idle(4);
    chk("t4_ninth_issued", 32'(log_addr.size() - base), 32'd9);
    if (log_addr.size() - base == 9) chk("t4_ninth_addr", log_addr[base+8], 25'h3008);
    for (int i = 0; i < 8; i++) begin
      ret(256'(i) + R1);
      tick();
    end
    chk("t4_drained_err", err_flags, 5'b00000);

    // Overflow while busy, then underflow with no reads outstanding.
    base = log_addr.size();
    ram_bus.ram_busy = 1'b1;
    cam_wr_req = 1; cam_wr_addr = 25'h400; cam_wr_data = DA;
    tick();
    cam_wr_addr = 25'h401; cam_wr_data = DB;
    tick();
    cam_wr_req = 0;
    chk("t5_ovf_cam", err_flags[0], 1'b1);
    ram_bus.ram_busy = 1'b0;
    idle(4);
    chk("t5_one_write", 32'(log_addr.size() - base), 32'd1);
    if (log_addr.size() - base == 1) begin
      chk("t5_first_addr", log_addr[base], 25'h400);
      chk("t5_first_data", log_data[base], DA);
    end
    ret(R1);
    chk("t5_underflow", err_flags, 5'b10001);
    chk("t5_no_valid", {vga_rd_valid, hdr_rd_valid}, 2'b00);
    idle(2);

    // Reset while a command is on the bus.
    tm_wr_req = 1; tm_wr_addr = 25'h500; tm_wr_data = DT;
    hdr_rd_req = 1; hdr_rd_addr = 25'h501;
    tick();
    tm_wr_req = 0; hdr_rd_req = 0;
    tick();
    chk("t6_in_issue", ram_bus.ram_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_req_cleared", ram_bus.ram_req, 1'b0);
    chk("t6_slots_cleared", slot_busy, 4'b0000);
    chk("t6_err_cleared", err_flags, 5'b00000);
    idle(4);

    // Request on the grant cycle reloads the slot without overflow.
    base = log_addr.size();
    cam_wr_req = 1; cam_wr_addr = 25'h700; cam_wr_data = D1;
    tick();
    cam_wr_req = 0;
    tick();
    chk("t7_issue", ram_bus.ram_req, 1'b1);
    cam_wr_req = 1; cam_wr_addr = 25'h701; cam_wr_data = D2;
    tick();
    cam_wr_req = 0;
    chk("t7_no_ovf", err_flags, 5'b00000);
    chk("t7_reloaded", slot_busy, 4'b0001);
    idle(4);
    chk("t7_two_writes", 32'(log_addr.size() - base), 32'd2);
    if (log_addr.size() - base == 2) begin
      chk("t7_second_addr", log_addr[base+1], 25'h701);
      chk("t7_second_data", log_data[base+1], D2);
    end
    idle(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
